// File: rtl/approx_mult_err_stats_if.sv
// approx_mult_err_stats_if: sample input and report output bundle for the error-statistics collector
// in_*  : sample stream (valid/ready), operands a, b and approximate product r
// out_* : report record stream (valid/ready) with the window totals
// master drives samples and accepts reports; slave is the collector
interface approx_mult_err_stats_if #(
    parameter int CNT_W = 16,
    parameter int SUM_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [15:0]      in_r;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_err_cnt;
    logic [SUM_W-1:0] out_sum_abs;
    logic [SUM_W-1:0] out_bias;
    logic [15:0]      out_max_abs;
    logic [7:0]       out_max_a;
    logic [7:0]       out_max_b;
    logic             out_sat;

    modport master (
        output in_valid, in_a, in_b, in_r, out_ready,
        input  in_ready, out_valid, out_err_cnt, out_sum_abs, out_bias,
               out_max_abs, out_max_a, out_max_b, out_sat
    );

    modport slave (
        input  in_valid, in_a, in_b, in_r, out_ready,
        output in_ready, out_valid, out_err_cnt, out_sum_abs, out_bias,
               out_max_abs, out_max_a, out_max_b, out_sat
    );
endinterface

// File: rtl/approx_mult_err_stats.sv
// approx_mult_err_stats: windowed error statistics of an 8x8 approximate multiplier
// clk, rst_n : rising-edge clock, asynchronous active-low reset
// clear      : synchronous flush of pipe, accumulators and FSM
// bus        : slave side of approx_mult_err_stats_if (samples in, report out)
module approx_mult_err_stats #(
    parameter int WIN_LEN = 256,
    parameter int CNT_W   = 16,
    parameter int SUM_W   = 32
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   clear,
    approx_mult_err_stats_if.slave bus
);
    // Wide enough to hold any accumulator plus one 17-bit signed error without wrapping
    localparam int W = SUM_W + 18;
    localparam logic [W-1:0]        UMAX = (W'(1) << SUM_W) - W'(1);
    localparam logic signed [W-1:0] BMAX = (W'(1) << (SUM_W - 1)) - W'(1);
    localparam logic signed [W-1:0] BMIN = ~BMAX;

    typedef enum logic [1:0] {ACCUM, DRAIN, REPORT} state_t;

    state_t            state;
    logic              v1;
    logic [7:0]        a1, b1;
    logic [15:0]       r1;
    logic [CNT_W-1:0]  cnt, ec;
    logic [SUM_W-1:0]  sa, bi;
    logic [15:0]       mx;
    logic [7:0]        ma, mb;
    logic              st;
    logic              ov, o_st;
    logic [CNT_W-1:0]  o_ec;
    logic [SUM_W-1:0]  o_sa, o_bi;
    logic [15:0]       o_mx;
    logic [7:0]        o_ma, o_mb;
    logic [15:0]       ex, ad;
    logic [16:0]       d;
    logic [W-1:0]      sn;
    logic signed [W-1:0] bn;
    logic [SUM_W-1:0]  sa_n, bi_n;
    logic              clamp;
    logic              acc;

    // in_ready is forced low while reset is asserted and rises immediately on release
    assign bus.in_ready    = rst_n & (state == ACCUM);
    assign acc             = bus.in_valid & bus.in_ready;
    assign bus.out_valid   = ov;
    assign bus.out_err_cnt = o_ec;
    assign bus.out_sum_abs = o_sa;
    assign bus.out_bias    = o_bi;
    assign bus.out_max_abs = o_mx;
    assign bus.out_max_a   = o_ma;
    assign bus.out_max_b   = o_mb;
    assign bus.out_sat     = o_st;

    always_comb begin
        ex    = 16'(a1) * 16'(b1);
        d     = {1'b0, ex} - {1'b0, r1};
        ad    = d[16] ? 16'(-d) : d[15:0];
        sn    = W'(sa) + W'(ad);
        bn    = W'($signed(bi)) + W'($signed(d));
        sa_n  = sn > UMAX ? UMAX[SUM_W-1:0] : sn[SUM_W-1:0];
        bi_n  = bn > BMAX ? BMAX[SUM_W-1:0] : bn < BMIN ? BMIN[SUM_W-1:0] : bn[SUM_W-1:0];
        clamp = (sn > UMAX) | (bn > BMAX) | (bn < BMIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
            {v1, a1, b1, r1} <= '0;
            cnt <= '0;
            {ec, sa, bi, mx, ma, mb, st} <= '0;
            {ov, o_ec, o_sa, o_bi, o_mx, o_ma, o_mb, o_st} <= '0;
        end else if (clear) begin
            state <= ACCUM;
            {v1, a1, b1, r1} <= '0;
            cnt <= '0;
            {ec, sa, bi, mx, ma, mb, st} <= '0;
            {ov, o_ec, o_sa, o_bi, o_mx, o_ma, o_mb, o_st} <= '0;
        end else begin
            v1 <= acc;
            if (acc) {a1, b1, r1} <= {bus.in_a, bus.in_b, bus.in_r};
            if (v1) begin
                ec <= ec + CNT_W'(d != 17'd0);
                sa <= sa_n;
                bi <= bi_n;
                st <= st | clamp;
                if (ad > mx) {mx, ma, mb} <= {ad, a1, b1};
            end
            case (state)
                ACCUM: if (acc) begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIN_LEN - 1)) state <= DRAIN;
                end
                // Leave once the last sample has been folded into the accumulators
                DRAIN: if (!v1) begin
                    state <= REPORT;
                    {ov, o_ec, o_sa, o_bi, o_mx, o_ma, o_mb, o_st} <= {1'b1, ec, sa, bi, mx, ma, mb, st};
                end
                REPORT: if (bus.out_ready) begin
                    state <= ACCUM;
                    cnt <= '0;
                    {ec, sa, bi, mx, ma, mb, st} <= '0;
                    {ov, o_ec, o_sa, o_bi, o_mx, o_ma, o_mb, o_st} <= '0;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_mult_err_stats.sv
// tb_approx_mult_err_stats: directed and randomized check of the error-statistics collector
module tb_approx_mult_err_stats;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    approx_mult_err_stats_if #(.CNT_W(16), .SUM_W(32)) m();
    approx_mult_err_stats_if #(.CNT_W(16), .SUM_W(8))  n();

    approx_mult_err_stats #(.WIN_LEN(4), .CNT_W(16), .SUM_W(32)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(m)
    );
    approx_mult_err_stats #(.WIN_LEN(2), .CNT_W(16), .SUM_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .bus(n)
    );

    typedef struct {
        longint ec, sa, bi, mx, ma, mb, st;
    } rep_t;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    logic [15:0] qr[$];

    task automatic chk(input string t, input longint g, input longint e);
        nchk++;
        assert (g === e) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", t, g, e);
        end
    endtask

    function automatic bit rdy(input bit s);
        return s ? n.in_ready : m.in_ready;
    endfunction

    function automatic bit ov(input bit s);
        return s ? n.out_valid : m.out_valid;
    endfunction

    task automatic drive(input bit s, input bit v, input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        if (s) begin
            n.in_valid = v; n.in_a = a; n.in_b = b; n.in_r = r;
        end else begin
            m.in_valid = v; m.in_a = a; m.in_b = b; m.in_r = r;
        end
    endtask

    task automatic ordy(input bit s, input bit v);
        if (s) n.out_ready = v;
        else m.out_ready = v;
    endtask

    function automatic rep_t obs(input bit s);
        rep_t o;
        if (s) begin
            o.ec = n.out_err_cnt; o.sa = n.out_sum_abs; o.bi = $signed(n.out_bias);
            o.mx = n.out_max_abs; o.ma = n.out_max_a; o.mb = n.out_max_b; o.st = n.out_sat;
        end else begin
            o.ec = m.out_err_cnt; o.sa = m.out_sum_abs; o.bi = $signed(m.out_bias);
            o.mx = m.out_max_abs; o.ma = m.out_max_a; o.mb = m.out_max_b; o.st = m.out_sat;
        end
        return o;
    endfunction

    // Window totals straight from the arithmetic definition, clamping at every step
    function automatic rep_t model(input bit s);
        rep_t   r = '{default: 0};
        longint sw = s ? 8 : 32;
        longint umax = (longint'(1) << sw) - 1;
        longint bmax = (longint'(1) << (sw - 1)) - 1;
        longint bmin = -bmax - 1;
        foreach (qa[i]) begin
            longint dd = longint'(qa[i]) * longint'(qb[i]) - longint'(qr[i]);
            longint aa = dd < 0 ? -dd : dd;
            if (dd != 0) r.ec++;
            r.sa += aa;
            if (r.sa > umax) begin r.sa = umax; r.st = 1; end
            r.bi += dd;
            if (r.bi > bmax) begin r.bi = bmax; r.st = 1; end
            if (r.bi < bmin) begin r.bi = bmin; r.st = 1; end
            if (aa > r.mx) begin r.mx = aa; r.ma = qa[i]; r.mb = qb[i]; end
        end
        return r;
    endfunction

    task automatic cmp(input bit s, input rep_t e, input string t);
        rep_t o = obs(s);
        chk({t, "_err_cnt"}, o.ec, e.ec);
        chk({t, "_sum_abs"}, o.sa, e.sa);
        chk({t, "_bias"},    o.bi, e.bi);
        chk({t, "_max_abs"}, o.mx, e.mx);
        chk({t, "_max_a"},   o.ma, e.ma);
        chk({t, "_max_b"},   o.mb, e.mb);
        chk({t, "_sat"},     o.st, e.st);
    endtask

    // Called at a falling edge; holds the sample until accepted, returns one falling edge after
    task automatic push(input bit s, input logic [7:0] a, input logic [7:0] b, input logic [15:0] r);
        int k = 0;
        drive(s, 1'b1, a, b, r);
        while (!rdy(s) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("accept_wait", longint'(k < 40), 1);
        @(negedge clk);
        drive(s, 1'b0, 8'd0, 8'd0, 16'd0);
        qa.push_back(a); qb.push_back(b); qr.push_back(r);
    endtask

    // Called right after the last push: checks latency, stall stability and the handshake
    task automatic report(input bit s, input int stall, input bit hold_valid, input string t);
        rep_t e = model(s);
        rep_t z = '{default: 0};
        chk({t, "_lat0"}, ov(s), 0);
        @(negedge clk);
        chk({t, "_lat1"}, ov(s), 0);
        @(negedge clk);
        chk({t, "_lat2"}, ov(s), 1);
        cmp(s, e, t);
        if (hold_valid) drive(s, 1'b1, 8'd1, 8'd1, 16'd7);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({t, "_stall_valid"}, ov(s), 1);
            chk({t, "_stall_ready"}, rdy(s), 0);
            cmp(s, e, {t, "_stall"});
        end
        drive(s, 1'b0, 8'd0, 8'd0, 16'd0);
        ordy(s, 1'b1);
        @(negedge clk);
        ordy(s, 1'b0);
        chk({t, "_post_valid"}, ov(s), 0);
        chk({t, "_post_ready"}, rdy(s), 1);
        cmp(s, z, {t, "_post"});
        qa.delete(); qb.delete(); qr.delete();
    endtask

    initial begin
        rep_t z = '{default: 0};
        drive(0, 1'b0, 8'd0, 8'd0, 16'd0);
        drive(1, 1'b0, 8'd0, 8'd0, 16'd0);
        ordy(0, 1'b0);
        ordy(1, 1'b0);
        #1;
        chk("rst_in_ready", m.in_ready, 0);
        chk("rst_out_valid", m.out_valid, 0);
        cmp(0, z, "rst");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready", m.in_ready, 1);
        chk("rel_in_ready_n", n.in_ready, 1);
        @(negedge clk);

        // exact window
        push(0, 3, 5, 15); push(0, 2, 2, 4); push(0, 10, 10, 100); push(0, 7, 7, 49);
        report(0, 0, 0, "exact");

        // mixed errors
        push(0, 3, 5, 14); push(0, 2, 2, 4); push(0, 10, 10, 96); push(0, 7, 7, 50);
        report(0, 0, 0, "mixed");

        // ties keep the earliest maximum
        push(0, 2, 2, 0); push(0, 1, 4, 0); push(0, 0, 0, 0); push(0, 1, 1, 5);
        report(0, 1, 0, "tie");

        // consumer stall with in_valid held high, then an exact window
        push(0, 9, 9, 80); push(0, 4, 4, 16); push(0, 200, 3, 601); push(0, 1, 1, 1);
        report(0, 10, 1, "stall");
        push(0, 3, 5, 15); push(0, 2, 2, 4); push(0, 10, 10, 100); push(0, 7, 7, 49);
        report(0, 0, 0, "after_stall");

        // narrow accumulators saturate
        push(1, 255, 255, 16'h0000); push(1, 255, 255, 16'h0000);
        report(1, 0, 0, "sat");

        // clear with a handshake in the same cycle drops the partial window
        push(0, 50, 50, 0); push(0, 60, 60, 0);
        drive(0, 1'b1, 8'd70, 8'd70, 16'd0);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        drive(0, 1'b0, 8'd0, 8'd0, 16'd0);
        chk("clr_out_valid", m.out_valid, 0);
        chk("clr_in_ready", m.in_ready, 1);
        qa.delete(); qb.delete(); qr.delete();
        push(0, 5, 6, 31); push(0, 8, 8, 60); push(0, 11, 2, 22); push(0, 0, 9, 3);
        report(0, 0, 0, "post_clear");

        // reset during REPORT, then samples with bubbles
        push(0, 100, 100, 0); push(0, 1, 1, 0); push(0, 1, 1, 0); push(0, 1, 1, 0);
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", m.out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", m.out_valid, 0);
        chk("mid_rst_ready", m.in_ready, 0);
        cmp(0, z, "mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        qa.delete(); qb.delete(); qr.delete();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            push(0, 8'(13 * i + 3), 8'(7 * i + 1), 16'(i * 11));
        end
        report(0, 0, 0, "bubbles");

        // randomized windows on the wide instance
        for (int w = 0; w < 8; w++) begin
            for (int i = 0; i < 4; i++) begin
                int a = $urandom_range(0, 255);
                int b = $urandom_range(0, 255);
                int r = a * b + int'($urandom_range(0, 64)) - 32;
                if ($urandom_range(0, 3) == 0) r = $urandom_range(0, 65535);
                if ($urandom_range(0, 3) == 0) r = a * b;
                r = r < 0 ? 0 : r > 65535 ? 65535 : r;
                if (i != 0) repeat ($urandom_range(0, 2)) @(negedge clk);
                push(0, 8'(a), 8'(b), 16'(r));
            end
            report(0, $urandom_range(0, 3), w[0], "rand");
        end

        // randomized windows on the saturating instance
        for (int w = 0; w < 6; w++) begin
            for (int i = 0; i < 2; i++) begin
                int a = $urandom_range(0, 255);
                int b = $urandom_range(0, 255);
                int r = w < 3 ? a * b + int'($urandom_range(0, 6)) - 3 : int'($urandom_range(0, 65535));
                r = r < 0 ? 0 : r > 65535 ? 65535 : r;
                push(1, 8'(a), 8'(b), 16'(r));
            end
            report(1, $urandom_range(0, 2), 0, "rand_sat");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end
endmodule
